// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and small helpers used by the scanout path.
package vga_timing_pkg;

    localparam int DEF_HOR_ACTIVE_PIXELS = 640;
    localparam int DEF_HOR_FRONT_PORCH   = 16;
    localparam int DEF_HOR_SYNC_PULSE    = 96;
    localparam int DEF_HOR_BACK_PORCH    = 48;
    localparam int DEF_VER_ACTIVE_PIXELS = 480;
    localparam int DEF_VER_FRONT_PORCH   = 10;
    localparam int DEF_VER_SYNC_PULSE    = 2;
    localparam int DEF_VER_BACK_PORCH    = 33;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic in_range(input int cnt, input int lo, input int hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical position counters advancing on ce, with raw (unregistered)
// active window, active-low sync levels and end-of-frame indication.
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
    parameter int HOR_FRONT_PORCH   = DEF_HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PULSE    = DEF_HOR_SYNC_PULSE,
    parameter int HOR_BACK_PORCH    = DEF_HOR_BACK_PORCH,
    parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
    parameter int VER_FRONT_PORCH   = DEF_VER_FRONT_PORCH,
    parameter int VER_SYNC_PULSE    = DEF_VER_SYNC_PULSE,
    parameter int VER_BACK_PORCH    = DEF_VER_BACK_PORCH,
    localparam int H_TOTAL = total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC_PULSE, HOR_BACK_PORCH),
    localparam int V_TOTAL = total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC_PULSE, VER_BACK_PORCH),
    localparam int H_CNT_W = $clog2(H_TOTAL),
    localparam int V_CNT_W = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               active,
    output logic               hsync_raw,
    output logic               vsync_raw,
    output logic               frame_wrap
);

    localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);
    localparam int H_SYNC_LO = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int V_SYNC_LO = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;

    logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign active     = (int'(h_cnt_q) < HOR_ACTIVE_PIXELS) && (int'(v_cnt_q) < VER_ACTIVE_PIXELS);
    assign hsync_raw  = !in_range(int'(h_cnt_q), H_SYNC_LO, H_SYNC_LO + HOR_SYNC_PULSE - 1);
    assign vsync_raw  = !in_range(int'(v_cnt_q), V_SYNC_LO, V_SYNC_LO + VER_SYNC_PULSE - 1);
    assign frame_wrap = ce && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer scanout: VGA timing, 1-bit pixel reads and the buffer swap pulse.
// Optional checkerboard override enabled by VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
    import vga_timing_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
    parameter int HOR_FRONT_PORCH   = DEF_HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PULSE    = DEF_HOR_SYNC_PULSE,
    parameter int HOR_BACK_PORCH    = DEF_HOR_BACK_PORCH,
    parameter int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
    parameter int VER_FRONT_PORCH   = DEF_VER_FRONT_PORCH,
    parameter int VER_SYNC_PULSE    = DEF_VER_SYNC_PULSE,
    parameter int VER_BACK_PORCH    = DEF_VER_BACK_PORCH,
    localparam int RD_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS),
    localparam int H_TOTAL = total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC_PULSE, HOR_BACK_PORCH),
    localparam int V_TOTAL = total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC_PULSE, VER_BACK_PORCH),
    localparam int H_CNT_W = $clog2(H_TOTAL),
    localparam int V_CNT_W = $clog2(V_TOTAL)
) (
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic                     pattern_sel,
`endif
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    output logic                     rd_en,
    output logic [RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic                     rd_data,
    output logic                     swap,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     de,
    output logic                     pixel
);

    localparam logic [H_CNT_W-1:0] H_LAST     = H_CNT_W'(H_TOTAL - 1);
    localparam logic [V_CNT_W-1:0] V_LAST_ACT = V_CNT_W'(VER_ACTIVE_PIXELS - 1);

    logic [H_CNT_W-1:0] h_cnt_p0;
    logic [V_CNT_W-1:0] v_cnt_p0;
    logic               active_p0, hsync_raw_p0, vsync_raw_p0, frame_wrap_p0;

    vga_sync_counter #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
        .HOR_SYNC_PULSE    (HOR_SYNC_PULSE),
        .HOR_BACK_PORCH    (HOR_BACK_PORCH),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .VER_FRONT_PORCH   (VER_FRONT_PORCH),
        .VER_SYNC_PULSE    (VER_SYNC_PULSE),
        .VER_BACK_PORCH    (VER_BACK_PORCH)
    ) u_sync_counter (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .h_cnt      (h_cnt_p0),
        .v_cnt      (v_cnt_p0),
        .active     (active_p0),
        .hsync_raw  (hsync_raw_p0),
        .vsync_raw  (vsync_raw_p0),
        .frame_wrap (frame_wrap_p0)
    );

    // ---- stage 0: read request and address, swap on the edge into line VER_ACTIVE_PIXELS
    logic [RD_ADDR_WIDTH-1:0] addr_q, addr_d;

    assign rd_en   = rst && ce && active_p0;
    assign rd_addr = addr_q;
    assign swap    = rst && ce && (h_cnt_p0 == H_LAST) && (v_cnt_p0 == V_LAST_ACT);

    always_comb begin
        addr_d = addr_q;
        if (frame_wrap_p0) begin
            addr_d = '0;
        end else if (rd_en) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // ---- stage 1: registered timing outputs, aligned with the RAM's registered read data
    logic hsync_p1_q, hsync_p1_d;
    logic vsync_p1_q, vsync_p1_d;
    logic de_p1_q, de_p1_d;
    logic pat_p1_q, pat_p1_d;

    always_comb begin
        hsync_p1_d = hsync_p1_q;
        vsync_p1_d = vsync_p1_q;
        de_p1_d    = de_p1_q;
        pat_p1_d   = pat_p1_q;
        if (ce) begin
            hsync_p1_d = hsync_raw_p0;
            vsync_p1_d = vsync_raw_p0;
            de_p1_d    = active_p0;
            pat_p1_d   = h_cnt_p0[3] ^ v_cnt_p0[3];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            hsync_p1_q <= 1'b1;
            vsync_p1_q <= 1'b1;
            de_p1_q    <= 1'b0;
            pat_p1_q   <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            hsync_p1_q <= hsync_p1_d;
            vsync_p1_q <= vsync_p1_d;
            de_p1_q    <= de_p1_d;
            pat_p1_q   <= pat_p1_d;
        end
    end

    assign hsync = hsync_p1_q;
    assign vsync = vsync_p1_q;
    assign de    = de_p1_q;

    // rd_data is the RAM's own register, loaded on the read edge and held until the
    // next read, so gating it with de_p1_q gives the same one-tick latency as de.
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    assign pixel = de_p1_q && (pattern_sel ? pat_p1_q : rd_data);
`else
    logic unused_pat;
    assign unused_pat = pat_p1_q;
    assign pixel      = de_p1_q && rd_data;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout with reduced timing; expected outputs are computed
// from the count of ce ticks since reset and a stored framebuffer image.
module tb_vga_scanout;

    localparam int HA  = 16, HFP = 2, HSP = 3, HBP = 3;
    localparam int VA  = 12, VFP = 2, VSP = 2, VBP = 3;
    localparam int HT  = HA + HFP + HSP + HBP;
    localparam int VT  = VA + VFP + VSP + VBP;
    localparam int FRAME = HT * VT;
    localparam int AW  = $clog2(HA * VA);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce  = 1'b0;
    logic          rd_data = 1'b0;
    logic          rd_en, swap, hsync, vsync, de, pixel;
    logic [AW-1:0] rd_addr;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic          pattern_sel = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int n     = 0;
    int swaps = 0;
    int de_cnt = 0;
    bit img [HA*VA];

    vga_scanout #(
        .HOR_ACTIVE_PIXELS (HA),
        .HOR_FRONT_PORCH   (HFP),
        .HOR_SYNC_PULSE    (HSP),
        .HOR_BACK_PORCH    (HBP),
        .VER_ACTIVE_PIXELS (VA),
        .VER_FRONT_PORCH   (VFP),
        .VER_SYNC_PULSE    (VSP),
        .VER_BACK_PORCH    (VBP)
    ) dut (
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .swap    (swap),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de),
        .pixel   (pixel)
    );

    always #5 clk = ~clk;

    // framebuffer with one clock of read latency; data held until the next read
    always @(posedge clk) begin
        if (rd_en) rd_data <= img[int'(rd_addr)];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (tick=%0d t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    // outputs after nn ce ticks: they describe screen position nn-1 of the frame
    function automatic void expect_out(input int nn, output bit hs, output bit vs,
                                       output bit d, output bit px);
        int q, h, v;
        if (nn == 0) begin
            hs = 1'b1; vs = 1'b1; d = 1'b0; px = 1'b0;
        end else begin
            q  = (nn - 1) % FRAME;
            h  = q % HT;
            v  = q / HT;
            d  = (h < HA) && (v < VA);
            hs = !((h >= HA + HFP) && (h < HA + HFP + HSP));
            vs = !((v >= VA + VFP) && (v < VA + VFP + VSP));
            px = d ? img[v*HA + h] : 1'b0;
        end
    endfunction

    task automatic step(input logic ce_v);
        int p, h, v;
        bit ers, hs, vs, d, px;
        @(negedge clk);
        ce = ce_v;
        #1;
        p   = n % FRAME;
        h   = p % HT;
        v   = p / HT;
        ers = rst && ce_v && (h < HA) && (v < VA);
        chk("rd_en", 32'(rd_en), 32'(ers));
        if (ers) chk("rd_addr", 32'(rd_addr), v*HA + h);
        chk("swap", 32'(swap), 32'(rst && ce_v && (p == VA*HT - 1)));
        expect_out(n, hs, vs, d, px);
        chk("hsync", 32'(hsync), 32'(hs));
        chk("vsync", 32'(vsync), 32'(vs));
        chk("de",    32'(de),    32'(d));
        chk("pixel", 32'(pixel), 32'(px));
        if (swap === 1'b1) swaps++;
        if (ce_v && de === 1'b1) de_cnt++;
        @(posedge clk);
        if (ce_v && rst) n++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd_en"},   32'(rd_en),   0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_hsync"},   32'(hsync),   1);
        chk({tag, "_vsync"},   32'(vsync),   1);
        chk({tag, "_de"},      32'(de),      0);
        chk({tag, "_pixel"},   32'(pixel),   0);
        chk({tag, "_swap"},    32'(swap),    0);
    endtask

    initial begin
        int target;
        foreach (img[i]) img[i] = 1'($urandom);

        // reset held with ce high
        rst = 1'b0;
        ce  = 1'b1;
        #12;
        chk_reset_vals("rst0");
        @(posedge clk);
        #1 rst = 1'b1;

        // ce every clk for two frames
        swaps = 0; de_cnt = 0;
        repeat (2 * FRAME) step(1'b1);
        chk("de_ticks_2frames", de_cnt, 2 * HA * VA);
        chk("swaps_2frames", swaps, 2);

        // ce every 4th clk for one frame
        swaps = 0;
        for (int i = 0; i < 4 * FRAME; i++) step((i % 4) == 0);
        chk("swaps_sparse_frame", swaps, 1);

        // random ce until mid-frame, then asynchronous reset
        target = 7 * HT + 9;
        for (int i = 0; i < 4000 && (n % FRAME) != target; i++) step(1'($urandom_range(0, 1)));
        chk("midrst_reached", 32'((n % FRAME) == target), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        ce = 1'b1;
        n  = 0;
        #1;
        chk_reset_vals("midrst");
        repeat (3) step(1'b1);
        #1 rst = 1'b1;

        // no swap before line VA of the new frame, then keep checking a full frame
        swaps = 0;
        for (int i = 0; i < 3000 && n < VA*HT - 1; i++) step(1'($urandom_range(0, 1)));
        chk("no_early_swap", swaps, 0);
        chk("early_phase_reached", 32'(n >= VA*HT - 1), 1);
        swaps = 0;
        while (n < FRAME + 5) step(1'($urandom_range(0, 3) != 0));
        chk("swap_after_restart", swaps, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
